// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg : shared CPU types (word, icache FSM state, icache frame)
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Widest possible tag (index width 0); narrower tags are zero-extended.
  localparam int ICACHE_TAG_MAX = 30;

  typedef enum logic [0:0] {
    COMPARE = 1'b0,
    FETCH   = 1'b1
  } icache_state_t;

  typedef struct packed {
    logic                      valid;
    logic [ICACHE_TAG_MAX-1:0] tag;
    word_t                     data;
  } icache_frame_t;

endpackage

`default_nettype wire

// File: rtl/icache_responder_if.sv
// ---------------------------------------------------------------------------
// icache_responder_if : datapath-side and memory-side icache signals
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface icache_responder_if;
  import cpu_types_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  flush;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;
  word_t hitcnt;
  word_t misscnt;

  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hitcnt, misscnt
  );

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr, hitcnt, misscnt
  );

endinterface

`default_nettype wire

// File: rtl/icache_frames.sv
// ---------------------------------------------------------------------------
// icache_frames : direct-mapped valid/tag/data store, one write port and a
//                 combinational read port
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module icache_frames
  import cpu_types_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 32 - IDX_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr_all,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  word_t             i_wr_data,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output icache_frame_t     o_rd
);

  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag  [SETS];
  word_t            r_data [SETS];

  // A clear on the same edge as a write wins, so a flushed fill stays invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_clr_all) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  always_comb begin
    o_rd.valid = r_valid[i_rd_idx];
    o_rd.tag   = ICACHE_TAG_MAX'(r_tag[i_rd_idx]);
    o_rd.data  = r_data[i_rd_idx];
  end

endmodule

`default_nettype wire

// File: rtl/icache_responder.sv
// ---------------------------------------------------------------------------
// icache_responder : direct-mapped one-word-per-frame instruction cache with
//                    a COMPARE/FETCH miss handler and hit/miss counters
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module icache_responder
  import cpu_types_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int IDX_W = 4
) (
  input  logic                CLK,
  input  logic                nRST,
  icache_responder_if.slave   bus
);

  localparam int TAG_W = 32 - IDX_W - 2;

  icache_state_t    r_state;
  word_t            r_miss_addr;
  word_t            r_hitcnt;
  word_t            r_misscnt;
  logic             r_flush_pend;

  icache_state_t    w_next;
  icache_frame_t    w_rd;
  logic             w_hit;
  logic             w_miss;
  logic             w_fill;
  logic             w_clr_all;
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_wr_idx;
  logic [TAG_W-1:0] w_req_tag;
  logic [TAG_W-1:0] w_fill_tag;
  logic             w_unused_addr_lsbs;

  assign w_rd_idx           = bus.imemaddr[IDX_W+1:2];
  assign w_req_tag          = bus.imemaddr[31:IDX_W+2];
  assign w_wr_idx           = r_miss_addr[IDX_W+1:2];
  assign w_fill_tag         = r_miss_addr[31:IDX_W+2];
  assign w_unused_addr_lsbs = ^{bus.imemaddr[1:0], r_miss_addr[1:0]};

  icache_frames #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_frames (
    .clk       (CLK),
    .rst       (nRST),
    .i_clr_all (w_clr_all),
    .i_we      (w_fill),
    .i_wr_idx  (w_wr_idx),
    .i_wr_tag  (w_fill_tag),
    .i_wr_data (bus.iload),
    .i_rd_idx  (w_rd_idx),
    .o_rd      (w_rd)
  );

  always_comb begin
    w_next    = r_state;
    w_hit     = 1'b0;
    w_miss    = 1'b0;
    w_fill    = 1'b0;
    w_clr_all = 1'b0;
    bus.iREN  = 1'b0;
    bus.iaddr = '0;
    case (r_state)
      COMPARE: begin
        w_hit     = bus.imemREN & w_rd.valid & ~bus.flush &
                    (w_rd.tag == ICACHE_TAG_MAX'(w_req_tag));
        w_miss    = bus.imemREN & ~w_hit;
        w_clr_all = bus.flush;
        if (w_miss) w_next = FETCH;
      end
      FETCH: begin
        bus.iREN  = 1'b1;
        bus.iaddr = {r_miss_addr[31:2], 2'b00};
        if (!bus.iwait) begin
          w_fill    = 1'b1;
          // A flush seen at any point of the fetch lands on the returning edge.
          w_clr_all = r_flush_pend | bus.flush;
          w_next    = COMPARE;
        end
      end
      default: w_next = COMPARE;
    endcase
    bus.ihit     = w_hit;
    bus.imemload = w_hit ? w_rd.data : '0;
  end

  assign bus.hitcnt  = r_hitcnt;
  assign bus.misscnt = r_misscnt;

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      r_state      <= COMPARE;
      r_miss_addr  <= '0;
      r_hitcnt     <= '0;
      r_misscnt    <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_miss) r_miss_addr <= bus.imemaddr;
      if (w_hit && (r_hitcnt != '1)) r_hitcnt <= r_hitcnt + 32'd1;
      if (w_miss && (r_misscnt != '1)) r_misscnt <= r_misscnt + 32'd1;
      if (r_state == FETCH && bus.iwait) r_flush_pend <= r_flush_pend | bus.flush;
      else                               r_flush_pend <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icache_responder.sv
// ---------------------------------------------------------------------------
// tb_icache_responder : randomized self-checking bench against a word-address
//                       cache model
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_icache_responder;
  import cpu_types_pkg::*;

  localparam int SETS = 16;

  logic CLK;
  logic nRST;

  icache_responder_if bus ();

  icache_responder #(.SETS(SETS), .IDX_W(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp;
  int n_bad;

  // Reference: each frame remembers which word address it holds.
  bit          m_valid [SETS];
  logic [29:0] m_word  [SETS];
  logic [31:0] m_data  [SETS];
  int unsigned m_hits;
  int unsigned m_misses;

  task automatic model_clear();
    for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
  endtask

  task automatic idle();
    @(negedge CLK);
    bus.imemREN = 1'b0;
    bus.flush   = 1'b0;
    bus.iwait   = 1'b1;
    #1;
  endtask

  // mode: 0 plain, 1 flush pulse in FETCH, 2 imemREN dropped in FETCH,
  //       3 imemaddr scrambled in FETCH
  task automatic access(input logic [31:0] addr, input logic [31:0] val,
                        input int nwait, input int mode);
    logic [29:0] wa;
    int          ix;
    logic        exp_hit;
    wa      = addr[31:2];
    ix      = int'(wa % SETS);
    exp_hit = m_valid[ix] && (m_word[ix] == wa);
    @(negedge CLK);
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    bus.flush    = 1'b0;
    bus.iwait    = 1'b1;
    #1;
    n_cmp++;
    if (bus.ihit !== exp_hit) begin
      n_bad++;
      $display("FAIL lookup_hit addr=%h got=%b want=%b", addr, bus.ihit, exp_hit);
    end
    if (exp_hit) begin
      m_hits++;
      n_cmp++;
      if (bus.imemload !== m_data[ix]) begin
        n_bad++;
        $display("FAIL hit_data addr=%h got=%h want=%h", addr, bus.imemload, m_data[ix]);
      end
      return;
    end
    m_misses++;
    for (int k = 0; k <= nwait; k++) begin
      @(negedge CLK);
      bus.iwait = (k < nwait);
      bus.iload = (k < nwait) ? $urandom : val;
      bus.flush = (mode == 1 && k == 0);
      if (mode == 2) bus.imemREN = 1'b0;
      if (mode == 3) bus.imemaddr = $urandom;
      #1;
      n_cmp++;
      if (bus.iREN !== 1'b1 || bus.iaddr !== {wa, 2'b00} || bus.ihit !== 1'b0) begin
        n_bad++;
        $display("FAIL fetch_phase k=%0d iREN=%b iaddr=%h ihit=%b want iREN=1 iaddr=%h ihit=0",
                 k, bus.iREN, bus.iaddr, bus.ihit, {wa, 2'b00});
      end
    end
    if (mode == 1) model_clear();
    m_valid[ix] = (mode != 1);
    m_word[ix]  = wa;
    m_data[ix]  = val;
  endtask

  task automatic test_reset();
    nRST = 1'b1;
    bus.imemREN = 1'b0; bus.imemaddr = '0; bus.flush = 1'b0;
    bus.iwait = 1'b1; bus.iload = '0;
    repeat (2) @(negedge CLK);
    #1;
    n_cmp++;
    if (bus.ihit !== 1'b0 || bus.iREN !== 1'b0 || bus.iaddr !== 32'h0 ||
        bus.imemload !== 32'h0 || bus.hitcnt !== 32'h0 || bus.misscnt !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs ihit=%b iREN=%b iaddr=%h imemload=%h hit=%0d miss=%0d want all 0",
               bus.ihit, bus.iREN, bus.iaddr, bus.imemload, bus.hitcnt, bus.misscnt);
    end
    model_clear();
    m_hits = 0; m_misses = 0;
    @(negedge CLK);
    nRST = 1'b0;
  endtask

  task automatic test_basic();
    access(32'h0000_0040, 32'h2001_0005, 0, 0);
    access(32'h0000_0040, 32'h0, 0, 0);
    idle();
    n_cmp++;
    if (bus.misscnt !== 32'd1 || bus.hitcnt !== 32'd1) begin
      n_bad++;
      $display("FAIL basic_counters hit=%0d miss=%0d want hit=1 miss=1", bus.hitcnt, bus.misscnt);
    end
  endtask

  task automatic test_conflict();
    access(32'h0000_0080, 32'hABCD_0080, 0, 0);
    access(32'h0000_0040, 32'h1234_0040, 1, 0);
    access(32'h0000_0040, 32'h0, 0, 0);
    idle();
    n_cmp++;
    if (bus.misscnt !== 32'd3 || bus.misscnt !== m_misses) begin
      n_bad++;
      $display("FAIL conflict_misscnt got=%0d want=3", bus.misscnt);
    end
  endtask

  task automatic test_wait();
    access(32'h0000_1004, 32'hCAFE_1004, 5, 0);
    access(32'h0000_1004, 32'h0, 0, 0);
  endtask

  task automatic test_flush_fetch();
    access(32'h0000_0010, 32'h0BAD_0010, 2, 1);
    access(32'h0000_0010, 32'h600D_0010, 0, 0);
    access(32'h0000_0040, 32'h7777_0040, 0, 0);
    access(32'h0000_0040, 32'h0, 0, 0);
  endtask

  task automatic test_flush_compare();
    @(negedge CLK);
    bus.imemREN = 1'b0;
    bus.flush   = 1'b1;
    #1;
    n_cmp++;
    if (bus.ihit !== 1'b0 || bus.iREN !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_compare ihit=%b iREN=%b want 0 0", bus.ihit, bus.iREN);
    end
    model_clear();
    idle();
    access(32'h0000_0040, 32'h4444_0040, 0, 0);
  endtask

  task automatic test_halt();
    access(32'h0000_2008, 32'h5A5A_2008, 1, 2);
    idle();
    access(32'h0000_2008, 32'h0, 0, 0);
    idle();
    n_cmp++;
    if (bus.misscnt !== m_misses || bus.hitcnt !== m_hits) begin
      n_bad++;
      $display("FAIL halt_counters hit=%0d miss=%0d want hit=%0d miss=%0d",
               bus.hitcnt, bus.misscnt, m_hits, m_misses);
    end
  endtask

  task automatic test_addr_change();
    access(32'h0000_300C, 32'h3C3C_300C, 1, 3);
    access(32'h0000_300C, 32'h0, 0, 0);
  endtask

  task automatic test_reset_mid_fetch();
    access(32'h0000_0044, 32'h4545_0044, 0, 0);
    @(negedge CLK);
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0084;
    #1;
    @(negedge CLK);
    bus.iwait = 1'b1;
    #1;
    n_cmp++;
    if (bus.iREN !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_fetch iREN=%b want 1", bus.iREN);
    end
    #1 nRST = 1'b1;
    #1;
    n_cmp++;
    if (bus.iREN !== 1'b0 || bus.hitcnt !== 32'h0 || bus.misscnt !== 32'h0) begin
      n_bad++;
      $display("FAIL async_reset iREN=%b hit=%0d miss=%0d want 0 0 0",
               bus.iREN, bus.hitcnt, bus.misscnt);
    end
    bus.imemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b0;
    model_clear();
    m_hits = 0; m_misses = 0;
    access(32'h0000_0084, 32'h8484_0084, 0, 0);
    access(32'h0000_0044, 32'h4646_0044, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          md;
    for (int n = 0; n < 300; n++) begin
      a  = ({$urandom_range(0, 3)} << 6) | ({$urandom_range(0, 15)} << 2) | {$urandom_range(0, 3)};
      md = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      access(a, $urandom, int'($urandom_range(0, 3)), md);
      if ($urandom_range(0, 5) == 0) idle();
    end
    idle();
    n_cmp++;
    if (bus.hitcnt !== m_hits || bus.misscnt !== m_misses) begin
      n_bad++;
      $display("FAIL random_counters hit=%0d miss=%0d want hit=%0d miss=%0d",
               bus.hitcnt, bus.misscnt, m_hits, m_misses);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_conflict();
    test_wait();
    test_flush_fetch();
    test_flush_compare();
    test_halt();
    test_addr_change();
    test_reset_mid_fetch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/icache_responder.md
ICACHE_RESPONDER -- requirements
Module: icache_responder

Interface
REQ-001 Parameters: SETS, default 16, number of direct-mapped one-word frames; IDX_W, default 4, index width, log2(SETS).
REQ-002 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-high: asserted when 1, despite the codebase port name.
REQ-004 imemREN  input  1  datapath instruction read request.
REQ-005 imemaddr  input  32  datapath word address; bits [1:0] ignored.
REQ-006 ihit  output  1  requested word valid on imemload this cycle.
REQ-007 imemload  output  32  instruction returned to datapath.
REQ-008 flush  input  1  invalidate all frames.
REQ-009 iREN  output  1  memory-side read request.
REQ-010 iaddr  output  32  memory-side word address.
REQ-011 iwait  input  1  memory busy; iload is valid when iREN=1 and iwait=0.
REQ-012 iload  input  32  memory-side read data.
REQ-013 hitcnt, misscnt  output  32 each  saturating statistics counters.

Function
REQ-014 Address split: tag = imemaddr[31:IDX_W+2], idx = imemaddr[IDX_W+1:2]; frame = valid bit, tag, 32-bit data.
REQ-015 Two-state FSM: COMPARE and FETCH; reset state is COMPARE.
REQ-016 In COMPARE, ihit = imemREN & valid[idx] & (tag match), combinationally in the same cycle; imemload = frame data[idx].
REQ-017 In COMPARE, a miss (imemREN=1 and ihit=0) latches imemaddr into miss_addr and moves to FETCH next cycle; misscnt increments once per miss.
REQ-018 In FETCH, iREN=1 and iaddr={miss_addr[31:2],2'b00}; ihit=0.
REQ-019 In FETCH, while iwait=1, hold the state.
REQ-020 In FETCH, when iwait=0, write iload, the miss_addr tag and valid=1 to frame idx(miss_addr), then return to COMPARE; the hit is served on the following cycle, so minimum miss latency is 2 cycles plus the iwait cycles.
REQ-021 In COMPARE, iREN=0 and iaddr=0.
REQ-022 hitcnt increments on each cycle in which ihit=1; both counters saturate at 32'hFFFF_FFFF.
REQ-023 If imemREN falls during FETCH (datapath halt), the fetch still completes and fills the frame.
REQ-024 flush in COMPARE clears all valid bits next edge, and ihit is forced 0 that cycle.
REQ-025 flush in FETCH is deferred: clear all valid bits on the edge that returns to COMPARE, overriding that fill's valid bit.
REQ-026 imemaddr changing while in FETCH has no effect; miss_addr governs.
REQ-027 imemREN=0 in COMPARE: no counter change, no state change, ihit=0.

Reset
REQ-028 On nRST=1, asynchronously: state=COMPARE; all valid=0; miss_addr=0; hitcnt=misscnt=0.
REQ-029 Reset outputs: ihit=0, iREN=0, iaddr=0, imemload=0 (tag/data arrays need not reset, since valid=0 masks them).
REQ-030 Reset asserted mid-FETCH abandons the fetch; no frame is written.

Structure
REQ-031 The state enum icache_state_t {COMPARE, FETCH} and the icache frame struct belong in cpu_types_pkg; word_t comes from the same package.
REQ-032 Sub-module: one natural sub-module, icache_frames (valid/tag/data array with a single write port and a combinational read port).
REQ-033 Single always_ff for state and counters; next-state and outputs are computed in always_comb.

Verification
REQ-034 Reset -> imemREN=1, imemaddr=0x0000_0040 -> ihit=0 and FETCH next cycle; iREN=1, iaddr=0x40; iwait=0 with iload=0x2001_0005 -> the following cycle ihit=1, imemload=0x2001_0005, misscnt=1, hitcnt=1.
REQ-035 Conflict: fill 0x40, then request 0x80 (same idx, different tag) -> miss, refill; then re-request 0x40 -> miss again; misscnt=3.
REQ-036 iwait held 1 for 5 cycles in FETCH -> iREN stays 1, ihit stays 0 for all 5 cycles; fill occurs on the cycle iwait=0.
REQ-037 flush pulse during FETCH of 0x10 -> after return to COMPARE, request 0x10 misses again; previously filled frames also miss.
REQ-038 nRST pulsed mid-FETCH -> iREN=0 immediately (asynchronous), counters=0, a subsequent request to the same address misses.
REQ-039 imemREN dropped to 0 mid-FETCH, then raised with the same address after the fill -> ihit=1 in COMPARE, no additional miss counted.
